// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small write-side FIFO.
// Frames queued back-to-back go out with no idle gap between them.
module uart_tx_fifo #(
   parameter int BAUD_DIV   = 2604,
   parameter int FIFO_DEPTH = 8,
   parameter int PTR_W      = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       trmt,
   input  logic [7:0] tx_data,
   output logic       TX,
   output logic       full,
   output logic       empty,
   output logic       tx_done
);
   localparam int CW = $clog2(BAUD_DIV + 1);
   typedef enum logic {IDLE, TRANSMITTING} state_t;
   state_t           state;
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [PTR_W:0]   count;
   logic [8:0]       shift_reg;
   logic [3:0]       bit_cnt;
   logic [CW-1:0]    baud_cnt;
   logic             push, shift, last, load;
   assign full  = count == (PTR_W+1)'(FIFO_DEPTH);
   assign empty = count == '0;
   assign push  = trmt && !full;
   assign shift = state == TRANSMITTING && baud_cnt == '0;
   assign last  = shift && bit_cnt == 4'd9;
   assign load  = !empty && (state == IDLE || last);
   assign TX    = shift_reg[0];
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= tx_data;
   // A load at the end of a stop bit replaces that shift, so the next start bit follows directly.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= IDLE;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         shift_reg <= '1;
         bit_cnt   <= '0;
         baud_cnt  <= CW'(BAUD_DIV - 1);
         tx_done   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (load) rd_ptr <= rd_ptr + 1'b1;
         if (push != load) count <= push ? count + 1'b1 : count - 1'b1;
         if (load) begin
            shift_reg <= {mem[rd_ptr], 1'b0};
            bit_cnt   <= '0;
            baud_cnt  <= CW'(BAUD_DIV - 1);
            state     <= TRANSMITTING;
         end else if (shift) begin
            shift_reg <= {1'b1, shift_reg[8:1]};
            bit_cnt   <= bit_cnt + 4'd1;
            baud_cnt  <= CW'(BAUD_DIV - 1);
            if (last) state <= IDLE;
         end else if (state == TRANSMITTING) begin
            baud_cnt <= baud_cnt - 1'b1;
         end
         tx_done <= push ? 1'b0 : (last && empty) ? 1'b1 : tx_done;
      end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of framing, FIFO limits, reset and a loopback stream.
module tb_uart_tx_fifo;
   localparam int B = 8;
   logic       clk = 1'b0, rst_n = 1'b0, trmt = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       TX, full, empty, tx_done;
   int         checks = 0, failures = 0, cyc = 0, e1, bad, to;
   logic       rx_en = 1'b0;
   logic [7:0] rx_b;
   logic [7:0] rx_q [$];
   int         rx_bad = 0;
   uart_tx_fifo #(.BAUD_DIV(B), .FIFO_DEPTH(8), .PTR_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(tx_data),
      .TX(TX), .full(full), .empty(empty), .tx_done(tx_done)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic push(input logic [7:0] d);
      trmt = 1'b1;
      tx_data = d;
      step;
      trmt = 1'b0;
   endtask
   task automatic frame(input logic [7:0] d, input int skip, input string tag);
      int n = 0;
      logic [9:0] f = {1'b1, d, 1'b0};
      for (int k = skip; k < 10*B; k++) begin
         if (TX !== f[k/B] || tx_done !== 1'b0) n++;
         step;
      end
      chk(tag, n, 0);
   endtask
   task automatic do_reset;
      rst_n = 1'b0;
      step;
      step;
      rst_n = 1'b1;
      step;
   endtask
   // Independent line decoder sampling mid-bit.
   initial forever begin
      @(negedge clk);
      if (rx_en && TX === 1'b0) begin
         repeat (B/2) @(negedge clk);
         if (TX !== 1'b0) rx_bad++;
         for (int i = 0; i < 8; i++) begin
            repeat (B) @(negedge clk);
            rx_b[i] = TX;
         end
         repeat (B) @(negedge clk);
         if (TX !== 1'b1) rx_bad++;
         rx_q.push_back(rx_b);
      end
   end
   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end
   initial begin
      step;
      chk("rst_tx", TX, 1);
      chk("rst_full", full, 0);
      chk("rst_empty", empty, 1);
      chk("rst_done", tx_done, 0);
      rst_n = 1'b1;
      step;
      push(8'hA5);
      chk("t1_empty_e0", empty, 0);
      chk("t1_idle_e0", TX, 1);
      step;
      chk("t1_empty_e1", empty, 1);
      frame(8'hA5, 0, "t1_frame");
      chk("t1_done", tx_done, 1);
      chk("t1_empty_end", empty, 1);
      trmt = 1'b1;
      tx_data = 8'h00;
      step;
      chk("t2_done_clr", tx_done, 0);
      chk("t2_tx_e0", TX, 1);
      tx_data = 8'hFF;
      step;
      chk("t2_start", TX, 0);
      tx_data = 8'h3C;
      step;
      trmt = 1'b0;
      chk("t2_queued", empty, 0);
      frame(8'h00, 1, "t2_f0");
      frame(8'hFF, 0, "t2_f1");
      frame(8'h3C, 0, "t2_f2");
      chk("t2_done", tx_done, 1);
      push(8'h55);
      step;
      for (int i = 1; i <= 9; i++) begin
         trmt = 1'b1;
         tx_data = 8'(i);
         step;
         if (i == 7) chk("t3_full7", full, 0);
         if (i == 8) chk("t3_full8", full, 1);
      end
      trmt = 1'b0;
      chk("t3_full9", full, 1);
      frame(8'h55, 9, "t3_first");
      for (int i = 1; i <= 8; i++) frame(8'(i), 0, "t3_queued");
      chk("t3_done", tx_done, 1);
      chk("t3_empty", empty, 1);
      do_reset;
      push(8'h77);
      step;
      e1 = cyc;
      for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
      chk("t4_full", full, 1);
      while (cyc < e1 + 10*B - 1) step;
      push(8'hEE);
      chk("t4_drop", full, 0);
      chk("t4_load", TX, 0);
      push(8'h99);
      chk("t4_cnt7", full, 1);
      do_reset;
      push(8'h77);
      step;
      e1 = cyc;
      for (int i = 0; i < 3; i++) push(8'h20 + 8'(i));
      while (cyc < e1 + 10*B - 1) step;
      push(8'hEE);
      chk("t4b_load", TX, 0);
      for (int i = 0; i < 4; i++) push(8'h30 + 8'(i));
      chk("t4b_cnt7", full, 0);
      push(8'h40);
      chk("t4b_cnt8", full, 1);
      do_reset;
      push(8'hA1);
      e1 = cyc + 1;
      push(8'hB2);
      push(8'hC3);
      while (cyc < e1 + 4*B + B/2) step;
      chk("t5_pre_tx", TX, 0);
      chk("t5_pre_q", empty, 0);
      rst_n = 1'b0;
      #1;
      chk("t5_tx", TX, 1);
      chk("t5_empty", empty, 1);
      chk("t5_done", tx_done, 0);
      chk("t5_full", full, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bad = 0;
      for (int k = 0; k < 30*B; k++) begin
         if (TX !== 1'b1 || empty !== 1'b1) bad++;
         step;
      end
      chk("t5_idle", bad, 0);
      rx_en = 1'b1;
      for (int i = 0; i < 256; i++) begin
         to = 0;
         while (full && to < 20*B) begin
            step;
            to++;
         end
         if (full) chk("t6_full_to", full, 0);
         push(8'(i));
      end
      to = 0;
      while (!tx_done && to < 200*B) begin
         step;
         to++;
      end
      chk("t6_done", tx_done, 1);
      repeat (2*B) step;
      chk("t6_count", rx_q.size(), 256);
      bad = 0;
      for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== 8'(i)) bad++;
      chk("t6_data", bad, 0);
      chk("t6_framing", rx_bad, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
